dof: RTL and testbench

Decode-and-operand-fetch pipeline stage of the 32-bit five-stage RISC CPU, between IF and EX.
- Decodes the 32-bit instruction word into register addresses and control fields.
- Drives register-file read addresses combinationally.
- Selects operands (register data, PC, or an immediate constant).
- Registers the operands and control fields into the DOF/EX pipeline register.

---
 rtl/dof.sv | 128 ++++++++++++
 tb/tb_dof.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dof.sv
// Decode-and-operand-fetch stage: decodes IR, drives register-file read addresses,
// selects operands and registers everything into the DOF/EX pipeline register.
module dof (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] PC_M1,
    input  logic [31:0] IR,
    input  logic [31:0] A_DATA,
    input  logic [31:0] B_DATA,
    output logic [31:0] BUS_A,
    output logic [31:0] BUS_B,
    output logic [4:0]  AA,
    output logic [4:0]  BA,
    output logic        RW,
    output logic [4:0]  DA,
    output logic [1:0]  MD,
    output logic [1:0]  BS,
    output logic        PS,
    output logic        MW,
    output logic [4:0]  FS,
    output logic [4:0]  SH,
    output logic [31:0] PC_M2
);

    logic [6:0]  op;
    logic        rw_next;
    logic [1:0]  md_next;
    logic [1:0]  bs_next;
    logic        ps_next;
    logic        mw_next;
    logic [4:0]  fs_next;
    logic        ma;
    logic        mb;
    logic        cs;
    logic [31:0] const_value;
    logic [31:0] bus_a_next;
    logic [31:0] bus_b_next;

    assign op = IR[31:25];
    assign AA = IR[19:15];
    assign BA = IR[14:10];

    always_comb begin
        rw_next = 1'b0;
        md_next = 2'b00;
        bs_next = 2'b00;
        ps_next = 1'b0;
        mw_next = 1'b0;
        fs_next = 5'b00000;
        ma      = 1'b0;
        mb      = 1'b0;
        cs      = 1'b0;
        case (op)
            7'b0000010: begin rw_next = 1'b1; fs_next = 5'b00010; end
            7'b0000101: begin rw_next = 1'b1; fs_next = 5'b00101; end
            7'b1100101: begin rw_next = 1'b1; md_next = 2'b10; fs_next = 5'b00101; end
            7'b0001000: begin rw_next = 1'b1; fs_next = 5'b01000; end
            7'b0001010: begin rw_next = 1'b1; fs_next = 5'b01010; end
            7'b0001100: begin rw_next = 1'b1; fs_next = 5'b01100; end
            7'b0101110: begin rw_next = 1'b1; fs_next = 5'b01110; end
            7'b1000000: begin rw_next = 1'b1; end
            7'b0110000: begin rw_next = 1'b1; fs_next = 5'b11000; end
            7'b0110001: begin rw_next = 1'b1; fs_next = 5'b10100; end
            7'b0000001: begin mw_next = 1'b1; end
            7'b0100001: begin rw_next = 1'b1; md_next = 2'b01; end
            7'b0100010: begin rw_next = 1'b1; fs_next = 5'b00010; mb = 1'b1; cs = 1'b1; end
            7'b0100101: begin rw_next = 1'b1; fs_next = 5'b00101; mb = 1'b1; cs = 1'b1; end
            7'b0101000: begin rw_next = 1'b1; fs_next = 5'b01000; mb = 1'b1; end
            7'b0101010: begin rw_next = 1'b1; fs_next = 5'b01010; mb = 1'b1; end
            7'b0101100: begin rw_next = 1'b1; fs_next = 5'b01100; mb = 1'b1; end
            7'b1100010: begin rw_next = 1'b1; fs_next = 5'b00010; mb = 1'b1; end
            7'b1000101: begin rw_next = 1'b1; fs_next = 5'b00101; mb = 1'b1; end
            7'b1100001: begin bs_next = 2'b10; end
            7'b0100000: begin bs_next = 2'b01; mb = 1'b1; cs = 1'b1; end
            7'b1100000: begin bs_next = 2'b01; ps_next = 1'b1; mb = 1'b1; cs = 1'b1; end
            7'b1000100: begin bs_next = 2'b11; mb = 1'b1; cs = 1'b1; end
            7'b0110111: begin
                rw_next = 1'b1;
                bs_next = 2'b11;
                fs_next = 5'b00111;
                ma      = 1'b1;
                mb      = 1'b1;
                cs      = 1'b1;
            end
            default: ;
        endcase
    end

    // Upper constant bits replicate IM[14] only when sign extension is selected.
    assign const_value[14:0] = IR[14:0];
    generate
        for (genvar gi = 15; gi < 32; gi++) begin : g_const_ext
            assign const_value[gi] = cs & IR[14];
        end
    endgenerate

    assign bus_a_next = ma ? PC_M1 : A_DATA;
    assign bus_b_next = mb ? const_value : B_DATA;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            BUS_A <= '0;
            BUS_B <= '0;
            RW    <= 1'b0;
            DA    <= '0;
            MD    <= '0;
            BS    <= '0;
            PS    <= 1'b0;
            MW    <= 1'b0;
            FS    <= '0;
            SH    <= '0;
            PC_M2 <= '0;
        end else begin
            BUS_A <= bus_a_next;
            BUS_B <= bus_b_next;
            RW    <= rw_next;
            DA    <= IR[24:20];
            MD    <= md_next;
            BS    <= bs_next;
            PS    <= ps_next;
            MW    <= mw_next;
            FS    <= fs_next;
            SH    <= IR[4:0];
            PC_M2 <= PC_M1;
        end
    end

endmodule

// File: tb/tb_dof.sv
// Scoreboarded bench for the DOF stage: expected pipeline-register contents are
// queued when an instruction is driven and compared one clock later.
module tb_dof;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] PC_M1, IR, A_DATA, B_DATA;
    logic [31:0] BUS_A, BUS_B, PC_M2;
    logic [4:0]  AA, BA, DA, FS, SH;
    logic [1:0]  MD, BS;
    logic        RW, PS, MW;

    typedef struct packed {
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        mw;
        logic [4:0]  fs;
        logic [4:0]  sh;
        logic [31:0] pc_m2;
    } outs_t;

    outs_t obs;
    outs_t exp_v;
    outs_t sb[$];
    int    checks = 0;
    int    passed = 0;

    dof dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .PC_M1 (PC_M1),
        .IR    (IR),
        .A_DATA(A_DATA),
        .B_DATA(B_DATA),
        .BUS_A (BUS_A),
        .BUS_B (BUS_B),
        .AA    (AA),
        .BA    (BA),
        .RW    (RW),
        .DA    (DA),
        .MD    (MD),
        .BS    (BS),
        .PS    (PS),
        .MW    (MW),
        .FS    (FS),
        .SH    (SH),
        .PC_M2 (PC_M2)
    );

    always_comb obs = {BUS_A, BUS_B, RW, DA, MD, BS, PS, MW, FS, SH, PC_M2};

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Reference decode: packed row {rw, md, bs, ps, mw, fs, ma, mb, cs}.
    function automatic outs_t model(input logic [31:0] ir, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b);
        logic [14:0] c;
        logic [31:0] k;
        outs_t o;
        case (ir[31:25])
            7'b0000010: c = 15'b1_00_00_0_0_00010_000;
            7'b0000101: c = 15'b1_00_00_0_0_00101_000;
            7'b1100101: c = 15'b1_10_00_0_0_00101_000;
            7'b0001000: c = 15'b1_00_00_0_0_01000_000;
            7'b0001010: c = 15'b1_00_00_0_0_01010_000;
            7'b0001100: c = 15'b1_00_00_0_0_01100_000;
            7'b0101110: c = 15'b1_00_00_0_0_01110_000;
            7'b1000000: c = 15'b1_00_00_0_0_00000_000;
            7'b0110000: c = 15'b1_00_00_0_0_11000_000;
            7'b0110001: c = 15'b1_00_00_0_0_10100_000;
            7'b0000001: c = 15'b0_00_00_0_1_00000_000;
            7'b0100001: c = 15'b1_01_00_0_0_00000_000;
            7'b0100010: c = 15'b1_00_00_0_0_00010_011;
            7'b0100101: c = 15'b1_00_00_0_0_00101_011;
            7'b0101000: c = 15'b1_00_00_0_0_01000_010;
            7'b0101010: c = 15'b1_00_00_0_0_01010_010;
            7'b0101100: c = 15'b1_00_00_0_0_01100_010;
            7'b1100010: c = 15'b1_00_00_0_0_00010_010;
            7'b1000101: c = 15'b1_00_00_0_0_00101_010;
            7'b1100001: c = 15'b0_00_10_0_0_00000_000;
            7'b0100000: c = 15'b0_00_01_0_0_00000_011;
            7'b1100000: c = 15'b0_00_01_1_0_00000_011;
            7'b1000100: c = 15'b0_00_11_0_0_00000_011;
            7'b0110111: c = 15'b1_00_11_0_0_00111_111;
            default:    c = 15'b0;
        endcase
        k = c[0] ? {{17{ir[14]}}, ir[14:0]} : {17'b0, ir[14:0]};
        o.bus_a = c[2] ? pc : a;
        o.bus_b = c[1] ? k : b;
        o.rw    = c[14];
        o.md    = c[13:12];
        o.bs    = c[11:10];
        o.ps    = c[9];
        o.mw    = c[8];
        o.fs    = c[7:3];
        o.da    = ir[24:20];
        o.sh    = ir[4:0];
        o.pc_m2 = pc;
        return o;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        IR = ir; PC_M1 = pc; A_DATA = a; B_DATA = b;
        sb.push_back(model(ir, pc, a, b));
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        sb.delete();
        @(negedge CLOCK);
        checks++;
        if (obs !== '0) $display("FAIL reset_init got=%h want=0", obs);
        else passed++;
        RESET = 1'b0;
        drive(32'h04110400, 32'h11, 32'h5, 32'h7);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL reset_pre_load got=%h want=%h", obs, exp_v);
        else passed++;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (obs !== '0) $display("FAIL reset_async got=%h want=0", obs);
        else passed++;
        IR = 32'h000F8000;
        #1;
        checks++;
        if (AA !== 5'd31 || BA !== 5'd0) $display("FAIL reset_addr got AA=%0d BA=%0d want AA=31 BA=0", AA, BA);
        else passed++;
        @(posedge CLOCK); #1;
        checks++;
        if (obs !== '0) $display("FAIL reset_hold got=%h want=0", obs);
        else passed++;
        @(negedge CLOCK);
        RESET = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_add();
        @(negedge CLOCK);
        drive(32'h04110400, 32'h1, 32'h5, 32'h5);
        #1;
        checks++;
        if (AA !== 5'd2 || BA !== 5'd1) $display("FAIL add_addr got AA=%0d BA=%0d want AA=2 BA=1", AA, BA);
        else passed++;
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL add_sb got=%h want=%h", obs, exp_v);
        else passed++;
        checks++;
        if (RW !== 1'b1 || DA !== 5'd1 || FS !== 5'b00010 || BUS_A !== 32'd5 || BUS_B !== 32'd5 || PC_M2 !== 32'd1)
            $display("FAIL add_fields got RW=%b DA=%0d FS=%b A=%h B=%h PC=%h", RW, DA, FS, BUS_A, BUS_B, PC_M2);
        else passed++;
        $display("test_add done");
    endtask

    task automatic test_imm();
        @(negedge CLOCK);
        drive({7'b0100010, 5'd3, 5'd1, 15'h7FFF}, 32'h4, 32'h1, 32'h9);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || BUS_B !== 32'hFFFFFFFF || RW !== 1'b1 || FS !== 5'b00010)
            $display("FAIL adi got=%h want=%h BUS_B=%h want=ffffffff", obs, exp_v, BUS_B);
        else passed++;
        drive({7'b0101000, 5'd3, 5'd1, 15'h7FFF}, 32'h5, 32'h1, 32'h9);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || BUS_B !== 32'h00007FFF)
            $display("FAIL ani got=%h want=%h BUS_B=%h want=00007fff", obs, exp_v, BUS_B);
        else passed++;
        $display("test_imm done");
    endtask

    task automatic test_jml();
        @(negedge CLOCK);
        drive({7'b0110111, 5'd31, 5'd2, 15'd3}, 32'h20, 32'hAAAA, 32'hBBBB);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || BUS_A !== 32'h20 || BUS_B !== 32'd3 || BS !== 2'b11 || RW !== 1'b1 || FS !== 5'b00111)
            $display("FAIL jml got=%h want=%h", obs, exp_v);
        else passed++;
        $display("test_jml done");
    endtask

    task automatic test_back_to_back();
        @(negedge CLOCK);
        drive({7'b0000001, 5'd0, 5'd4, 5'd5, 10'h3}, 32'h30, 32'h100, 32'h200);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || MW !== 1'b1 || RW !== 1'b0) $display("FAIL b2b_st got=%h want=%h", obs, exp_v);
        else passed++;
        drive({7'b0100001, 5'd7, 5'd4, 15'h0}, 32'h31, 32'h104, 32'h204);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || MD !== 2'b01 || RW !== 1'b1 || MW !== 1'b0) $display("FAIL b2b_ld got=%h want=%h", obs, exp_v);
        else passed++;
        drive({7'b1100000, 5'd0, 5'd6, 15'h4001}, 32'h32, 32'h108, 32'h208);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || BS !== 2'b01 || PS !== 1'b1 || RW !== 1'b0) $display("FAIL b2b_bnz got=%h want=%h", obs, exp_v);
        else passed++;
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic [6:0] ops [26];
        ops = '{7'b0000000, 7'b0000010, 7'b0000101, 7'b1100101, 7'b0001000, 7'b0001010,
                7'b0001100, 7'b0101110, 7'b1000000, 7'b0110000, 7'b0110001, 7'b0000001,
                7'b0100001, 7'b0100010, 7'b0100101, 7'b0101000, 7'b0101010, 7'b0101100,
                7'b1100010, 7'b1000101, 7'b1100001, 7'b0100000, 7'b1100000, 7'b1000100,
                7'b0110111, 7'b1011011};
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK);
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) $display("FAIL rand_%0d got=%h want=%h", i, obs, exp_v);
                else passed++;
            end
            drive({ops[$urandom_range(25)], 25'($urandom)}, $urandom, $urandom, $urandom);
        end
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL rand_last got=%h want=%h", obs, exp_v);
        else passed++;
        $display("test_random done");
    endtask

    task automatic test_undefined();
        @(negedge CLOCK);
        drive({7'b1111111, 5'd9, 5'd3, 15'h7FFF}, 32'h40, 32'h12, 32'h34);
        @(negedge CLOCK);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || RW !== 1'b0 || MW !== 1'b0 || BS !== 2'b00 || FS !== 5'b0 || BUS_B !== 32'h34)
            $display("FAIL undef got=%h want=%h", obs, exp_v);
        else passed++;
        $display("test_undefined done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_jml();
        test_back_to_back();
        test_undefined();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
